// File: rtl/nios_onchip_memory_dp.sv
// True dual-port on-chip RAM with two Avalon-MM slave ports on one clock.
// Optional zero-fill sequencer after reset: define NIOS_ONCHIP_MEM_ZERO_FILL_EN.
module nios_onchip_memory_dp #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 12,
  parameter int READ_LATENCY = 1,
  parameter     INIT_FILE    = "nios_onchip_memory_dp.hex"
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [ADDR_WIDTH-1:0]   address2,
  input  logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic [DATA_WIDTH/8-1:0] byteenable2,
  input  logic                    chipselect,
  input  logic                    chipselect2,
  input  logic                    read,
  input  logic                    read2,
  input  logic                    write,
  input  logic                    write2,
  input  logic [DATA_WIDTH-1:0]   writedata,
  input  logic [DATA_WIDTH-1:0]   writedata2,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic [DATA_WIDTH-1:0]   readdata2,
  output logic                    readdatavalid,
  output logic                    readdatavalid2,
  output logic                    waitrequest,
  output logic                    waitrequest2
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Handshake: a request is taken on the edge where chipselect & (read|write)
  // is high and waitrequest is low; otherwise the master must hold it.
  // Reads have no backpressure: readdatavalid pulses once per accepted read.
  logic acc1, acc2, wr1_acc, wr2_acc, rd1_acc, rd2_acc;
  logic busy;

  assign waitrequest  = reset | busy;
  assign waitrequest2 = reset | busy;

  assign acc1    = chipselect  & (read  | write)  & ~waitrequest;
  assign acc2    = chipselect2 & (read2 | write2) & ~waitrequest2;
  assign wr1_acc = acc1 & write;
  assign wr2_acc = acc2 & write2;
  assign rd1_acc = acc1 & read  & ~write;
  assign rd2_acc = acc2 & read2 & ~write2;

  function automatic logic [DATA_WIDTH-1:0] merge_lanes(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [BE_W-1:0]       lanes,
    input logic                  en
  );
    logic [DATA_WIDTH-1:0] r;
    r = old_word;
    for (int b = 0; b < BE_W; b++)
      if (en && lanes[b]) r[b*8 +: 8] = new_word[b*8 +: 8];
    return r;
  endfunction

  // A read sees the other port's same-cycle write merged in (new data).
  logic [DATA_WIDTH-1:0] rd_word1, rd_word2;
  always_comb begin
    rd_word1 = merge_lanes(mem[address],  writedata2, byteenable2, wr2_acc && (address2 == address));
    rd_word2 = merge_lanes(mem[address2], writedata,  byteenable,  wr1_acc && (address  == address2));
  end

`ifdef NIOS_ONCHIP_MEM_ZERO_FILL_EN
  typedef enum logic {FILL, READY} fill_state_t;
  fill_state_t           fill_state, fill_state_d;
  logic [ADDR_WIDTH-1:0] fill_cnt_q, fill_cnt_d;
  logic                  fill_we;

  always_ff @(posedge clk) begin
    if (reset) begin
      fill_state <= FILL;
      fill_cnt_q <= '0;
    end else begin
      fill_state <= fill_state_d;
      fill_cnt_q <= fill_cnt_d;
    end
  end

  always_comb begin
    fill_state_d = fill_state;
    fill_cnt_d   = fill_cnt_q;
    fill_we      = 1'b0;
    case (fill_state)
      FILL: begin
        if (!reset) begin
          fill_we    = 1'b1;
          fill_cnt_d = fill_cnt_q + 1'b1;
          if (fill_cnt_q == '1) fill_state_d = READY;
        end
      end
      default: ;
    endcase
  end

  assign busy = (fill_state == FILL);
`else
  assign busy = 1'b0;
`endif

  // Port 2 lanes are written first so port 1 wins any shared lane.
  always_ff @(posedge clk) begin
`ifdef NIOS_ONCHIP_MEM_ZERO_FILL_EN
    if (fill_we) mem[fill_cnt_q] <= '0;
`endif
    for (int b = 0; b < BE_W; b++) begin
      if (wr2_acc && byteenable2[b]) mem[address2][b*8 +: 8] <= writedata2[b*8 +: 8];
      if (wr1_acc && byteenable[b])  mem[address][b*8 +: 8]  <= writedata[b*8 +: 8];
    end
  end

  logic                  rv1_q, rv2_q;
  logic [DATA_WIDTH-1:0] rd1_q, rd2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rv1_q <= 1'b0;
      rv2_q <= 1'b0;
      rd1_q <= '0;
      rd2_q <= '0;
    end else begin
      rv1_q <= rd1_acc;
      rv2_q <= rd2_acc;
      if (rd1_acc) rd1_q <= rd_word1;
      if (rd2_acc) rd2_q <= rd_word2;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  out_v1_q, out_v2_q;
    logic [DATA_WIDTH-1:0] out_d1_q, out_d2_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        out_v1_q <= 1'b0;
        out_v2_q <= 1'b0;
        out_d1_q <= '0;
        out_d2_q <= '0;
      end else begin
        out_v1_q <= rv1_q;
        out_v2_q <= rv2_q;
        if (rv1_q) out_d1_q <= rd1_q;
        if (rv2_q) out_d2_q <= rd2_q;
      end
    end

    assign readdatavalid  = out_v1_q;
    assign readdatavalid2 = out_v2_q;
    assign readdata       = out_d1_q;
    assign readdata2      = out_d2_q;
  end else begin : g_lat1
    assign readdatavalid  = rv1_q;
    assign readdatavalid2 = rv2_q;
    assign readdata       = rd1_q;
    assign readdata2      = rd2_q;
  end

endmodule
